// File: rtl/mesi_snoop_agent.sv
// Per-CPU MESI snoop agent: tag/state table lookup, write-back
// handshake, CPU enable relay and single-cycle bus acknowledge.
module mesi_snoop_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int OFFSET_BITS    = 2,
  parameter int INDEX_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic                      wb_req_o,
  output logic [ADDR_WIDTH-1:0]     wb_addr_o,
  input  logic                      wb_ack_i,
  output logic                      cpu_en_wr_o,
  output logic                      cpu_en_rd_o,
  input  logic                      cpu_done_i,
  input  logic                      fill_vld_i,
  input  logic [ADDR_WIDTH-1:0]     fill_addr_i,
  input  logic [1:0]                fill_state_i,
  output logic                      fill_rdy_o
);

  localparam int TAG_LO = OFFSET_BITS + INDEX_WIDTH;
  localparam int TAG_W  = ADDR_WIDTH - TAG_LO;
  localparam int LINE_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int LINES  = 1 << INDEX_WIDTH;

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = 1;
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = 2;
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = 3;
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = 4;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  typedef enum logic [1:0] {IDLE, WB, EN_WAIT, ACK} state_t;

  state_t                    state_q, state_d;
  logic [CBUS_CMD_WIDTH-1:0] cmd_q;
  logic [LINE_W-1:0]         line_q;
  logic                      en_wr_q, en_rd_q;
  logic [TAG_W-1:0]          tag_q [LINES];
  logic [1:0]                st_q  [LINES];

  logic [INDEX_WIDTH-1:0] idx_c, fill_idx, upd_idx;
  logic [TAG_W-1:0]       tag_c;
  logic [1:0]             st_c, upd_st;
  logic                   hit, upd, fill_ok;
  logic                   is_wr, is_rd, is_en;
  logic                   unused_ok;

  assign idx_c    = cbus_addr_i[TAG_LO-1:OFFSET_BITS];
  assign tag_c    = cbus_addr_i[ADDR_WIDTH-1:TAG_LO];
  assign fill_idx = fill_addr_i[TAG_LO-1:OFFSET_BITS];
  assign st_c     = st_q[idx_c];
  assign hit      = (tag_q[idx_c] == tag_c) && (st_c != ST_I);

  assign is_wr = (cbus_cmd_i == CMD_WR_SNOOP);
  assign is_rd = (cbus_cmd_i == CMD_RD_SNOOP);
  assign is_en = (cbus_cmd_i == CMD_EN_WR) ||
                 (cbus_cmd_i == CMD_EN_RD);

  assign unused_ok = ^{cbus_addr_i[OFFSET_BITS-1:0],
                       fill_addr_i[OFFSET_BITS-1:0]};

  always_comb begin
    state_d = state_q;
    upd     = 1'b0;
    upd_idx = idx_c;
    upd_st  = ST_I;
    fill_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          is_wr: begin
            if (hit && st_c == ST_M) begin
              state_d = WB;
            end else begin
              upd     = hit;
              state_d = ACK;
            end
          end
          is_rd: begin
            if (hit && st_c == ST_M) begin
              state_d = WB;
            end else begin
              upd     = hit && (st_c == ST_E);
              upd_st  = ST_S;
              state_d = ACK;
            end
          end
          is_en:   state_d = EN_WAIT;
          default: fill_ok = 1'b1;
        endcase
      end
      WB: begin
        upd_idx = line_q[INDEX_WIDTH-1:0];
        upd_st  = (cmd_q == CMD_WR_SNOOP) ? ST_I : ST_S;
        if (wb_ack_i) begin
          upd     = 1'b1;
          state_d = ACK;
        end
      end
      // The grant cycle itself never counts as completion.
      EN_WAIT: begin
        if (cpu_done_i && !(en_wr_q || en_rd_q)) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      line_q  <= '0;
      en_wr_q <= 1'b0;
      en_rd_q <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        st_q[i]  <= ST_I;
      end
    end else begin
      state_q <= state_d;
      en_wr_q <= (state_q == IDLE) && (cbus_cmd_i == CMD_EN_WR);
      en_rd_q <= (state_q == IDLE) && (cbus_cmd_i == CMD_EN_RD);
      if (state_q == IDLE && !fill_ok) begin
        cmd_q  <= cbus_cmd_i;
        line_q <= cbus_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
      end
      if (upd) begin
        st_q[upd_idx] <= upd_st;
      end else if (fill_ok && fill_vld_i) begin
        tag_q[fill_idx] <= fill_addr_i[ADDR_WIDTH-1:TAG_LO];
        st_q[fill_idx]  <= fill_state_i;
      end
    end
  end

  assign cbus_ack_o  = (state_q == ACK);
  assign wb_req_o    = (state_q == WB);
  assign wb_addr_o   = wb_req_o ? {line_q, {OFFSET_BITS{1'b0}}} : '0;
  assign cpu_en_wr_o = en_wr_q;
  assign cpu_en_rd_o = en_rd_q;
  assign fill_rdy_o  = fill_ok && !rst;

endmodule

// File: tb/tb_mesi_snoop_agent.sv
// Directed bench for mesi_snoop_agent: fills, snoops, write-backs,
// enable grants and reset abandonment.
module tb_mesi_snoop_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cbus_cmd_i;
  logic [31:0] cbus_addr_i;
  logic        cbus_ack_o;
  logic        wb_req_o;
  logic [31:0] wb_addr_o;
  logic        wb_ack_i;
  logic        cpu_en_wr_o;
  logic        cpu_en_rd_o;
  logic        cpu_done_i;
  logic        fill_vld_i;
  logic [31:0] fill_addr_i;
  logic [1:0]  fill_state_i;
  logic        fill_rdy_o;

  int tests = 0;
  int fails = 0;

  mesi_snoop_agent dut (
    .clk(clk), .rst(rst),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i),
    .cbus_ack_o(cbus_ack_o),
    .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i),
    .cpu_en_wr_o(cpu_en_wr_o), .cpu_en_rd_o(cpu_en_rd_o),
    .cpu_done_i(cpu_done_i),
    .fill_vld_i(fill_vld_i), .fill_addr_i(fill_addr_i),
    .fill_state_i(fill_state_i), .fill_rdy_o(fill_rdy_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'd0, WRS = 3'd1, RDS = 3'd2,
                         ENW = 3'd3;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] a, input logic [1:0] s);
    fill_vld_i = 1'b1; fill_addr_i = a; fill_state_i = s;
    #1 chk("fill_rdy_idle", 32'(fill_rdy_o), 1);
    tick();
    fill_vld_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cbus_cmd_i = NOP; cbus_addr_i = '0; wb_ack_i = 1'b0;
    cpu_done_i = 1'b0; fill_vld_i = 1'b0; fill_addr_i = '0;
    fill_state_i = '0;
    tick(); tick();
    chk("rst_fill_rdy", 32'(fill_rdy_o), 0);
    chk("rst_ack", 32'(cbus_ack_o), 0);
    chk("rst_wb_req", 32'(wb_req_o), 0);
    chk("rst_wb_addr", wb_addr_o, 0);
    chk("rst_en_wr", 32'(cpu_en_wr_o), 0);
    rst = 1'b0;
    #1 chk("post_rst_fill_rdy", 32'(fill_rdy_o), 1);

    // E line read-snooped: ack at N+1, no write-back
    fill(32'h10, 2'd2);
    cbus_cmd_i = RDS; cbus_addr_i = 32'h10;
    #1 chk("rd_fill_rdy_busy", 32'(fill_rdy_o), 0);
    tick();
    chk("rd_e_ack", 32'(cbus_ack_o), 1);
    chk("rd_e_no_wb", 32'(wb_req_o), 0);
    cbus_cmd_i = NOP; tick();
    chk("rd_e_ack_drop", 32'(cbus_ack_o), 0);

    // M line write-snooped, write-back acked after 3 cycles
    fill(32'h40, 2'd3);
    cbus_cmd_i = WRS; cbus_addr_i = 32'h43;
    tick();
    chk("wb_req_c1", 32'(wb_req_o), 1);
    chk("wb_addr", wb_addr_o, 32'h40);
    chk("wb_no_ack_c1", 32'(cbus_ack_o), 0);
    tick();
    chk("wb_req_c2", 32'(wb_req_o), 1);
    tick();
    chk("wb_req_c3", 32'(wb_req_o), 1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("wb_req_drop", 32'(wb_req_o), 0);
    chk("wb_ack", 32'(cbus_ack_o), 1);
    cbus_cmd_i = NOP; tick();
    chk("wb_ack_single", 32'(cbus_ack_o), 0);
    // line now I: no write-back on a repeat snoop
    cbus_cmd_i = WRS; cbus_addr_i = 32'h40;
    tick();
    chk("inv_ack", 32'(cbus_ack_o), 1);
    chk("inv_no_wb", 32'(wb_req_o), 0);
    cbus_cmd_i = NOP; tick();

    // Same index, different tag: miss, entry keeps M
    fill(32'h40, 2'd3);
    cbus_cmd_i = WRS; cbus_addr_i = 32'h80;
    tick();
    chk("miss_ack", 32'(cbus_ack_o), 1);
    chk("miss_no_wb", 32'(wb_req_o), 0);
    cbus_cmd_i = NOP; tick();
    cbus_cmd_i = WRS; cbus_addr_i = 32'h40;
    tick();
    chk("miss_kept_m", 32'(wb_req_o), 1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("fast_wb_ack", 32'(cbus_ack_o), 1);
    cbus_cmd_i = NOP; tick();

    // Enable write: done at N+1 ignored, done at N+4 -> ack N+5
    cbus_cmd_i = ENW; cbus_addr_i = 32'h0;
    tick();
    chk("en_wr_pulse", 32'(cpu_en_wr_o), 1);
    chk("en_rd_quiet", 32'(cpu_en_rd_o), 0);
    cpu_done_i = 1'b1;
    tick();
    cpu_done_i = 1'b0;
    chk("en_wr_single", 32'(cpu_en_wr_o), 0);
    chk("en_early_done", 32'(cbus_ack_o), 0);
    tick();
    chk("en_wait_n3", 32'(cbus_ack_o), 0);
    tick();
    cpu_done_i = 1'b1;
    tick();
    cpu_done_i = 1'b0;
    chk("en_ack", 32'(cbus_ack_o), 1);
    cbus_cmd_i = NOP; tick();
    chk("en_ack_single", 32'(cbus_ack_o), 0);

    // Fill held across a snoop write-back; lands once idle
    fill(32'h24, 2'd3);
    cbus_cmd_i = RDS; cbus_addr_i = 32'h24;
    fill_vld_i = 1'b1; fill_addr_i = 32'h24; fill_state_i = 2'd3;
    #1 chk("fill_blk_n", 32'(fill_rdy_o), 0);
    tick();
    chk("fill_wb_req", 32'(wb_req_o), 1);
    #1 chk("fill_blk_wb", 32'(fill_rdy_o), 0);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("fill_snoop_ack", 32'(cbus_ack_o), 1);
    #1 chk("fill_blk_ack", 32'(fill_rdy_o), 0);
    cbus_cmd_i = NOP; tick();
    #1 chk("fill_rdy_back", 32'(fill_rdy_o), 1);
    tick();
    fill_vld_i = 1'b0;
    cbus_cmd_i = WRS; cbus_addr_i = 32'h24;
    tick();
    chk("fill_overwrote_s", 32'(wb_req_o), 1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    cbus_cmd_i = NOP; tick();

    // Reset during write-back abandons it and clears the table
    fill(32'h30, 2'd3);
    cbus_cmd_i = WRS; cbus_addr_i = 32'h30;
    tick();
    chk("pre_rst_wb", 32'(wb_req_o), 1);
    rst = 1'b1; cbus_cmd_i = NOP;
    tick();
    chk("mid_rst_wb_req", 32'(wb_req_o), 0);
    chk("mid_rst_wb_addr", wb_addr_o, 0);
    chk("mid_rst_ack", 32'(cbus_ack_o), 0);
    rst = 1'b0;
    cbus_cmd_i = RDS; cbus_addr_i = 32'h30;
    tick();
    chk("post_rst_miss_ack", 32'(cbus_ack_o), 1);
    chk("post_rst_no_wb", 32'(wb_req_o), 0);
    cbus_cmd_i = NOP; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
